mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 19 +
 rtl/mul_seq_if.sv | 30 +++
 rtl/mul_seq.sv | 124 ++++++++++++
 tb/tb_mul_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the sequential shift-and-add multiplier:
// ALU opcodes driven to the external ALU and the controller state encoding.
package mul_seq_pkg;

   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned SHAMT_W    = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_NOP = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      SHL  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result and shared-ALU signals of mul_seq; the slave modport is the
// multiplier's view, the master modport the CPU-top view (requester plus ALU).
interface mul_seq_if #(
   parameter int unsigned bit_size = 32
) ();
   import mul_seq_pkg::*;

   logic                  start;
   logic [bit_size-1:0]   mcand_in;
   logic [bit_size-1:0]   mplier_in;
   logic                  busy;
   logic                  done;
   logic [bit_size-1:0]   product;
   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic [bit_size-1:0]   alu_src1;
   logic [bit_size-1:0]   alu_src2;
   logic [SHAMT_W-1:0]    alu_shamt;
   logic [bit_size-1:0]   alu_result;

   modport slave (
      input  start, mcand_in, mplier_in, alu_result,
      output busy, done, product, alu_ctrl, alu_src1, alu_src2, alu_shamt
   );

   modport master (
      output start, mcand_in, mplier_in, alu_result,
      input  busy, done, product, alu_ctrl, alu_src1, alu_src2, alu_shamt
   );

endinterface

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: one ADD/SHL pair per multiplier bit, with the
// arithmetic done by an external ALU driven from registered alu_* outputs.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int unsigned bit_size = 32
) (
   input  logic     clk,
   input  logic     rst,
   mul_seq_if.slave bus
);

   state_e                state_q, state_d;
   logic [bit_size-1:0]   acc_q, acc_d;
   logic [bit_size-1:0]   mcand_q, mcand_d;
   logic [bit_size-1:0]   mplier_q, mplier_d;
   logic [bit_size-1:0]   product_q, product_d;
   logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [bit_size-1:0]   src1_q, src1_d;
   logic [bit_size-1:0]   src2_q, src2_d;
   logic [SHAMT_W-1:0]    shamt_q, shamt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Next state and datapath; outputs are pre-decoded from the next state so
   // they can be registered and still match the state they belong to.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d    = '0;
               mcand_d  = bus.mcand_in;
               mplier_d = bus.mplier_in;
               if (bus.mplier_in == '0) begin
                  state_d   = DONE;
                  product_d = '0;
               end else begin
                  state_d = ADD;
               end
            end
         end
         ADD: begin
            if (mplier_q[0]) acc_d = bus.alu_result;
            state_d = SHL;
         end
         SHL: begin
            mcand_d  = bus.alu_result;
            mplier_d = mplier_q >> 1;
            if (mplier_d == '0) begin
               state_d   = DONE;
               product_d = acc_q;
            end else begin
               state_d = ADD;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ctrl_d  = ALU_NOP;
      src1_d  = '0;
      src2_d  = '0;
      shamt_d = '0;
      unique case (state_d)
         ADD: begin
            ctrl_d = ALU_ADD;
            src1_d = acc_d;
            src2_d = mcand_d;
         end
         SHL: begin
            ctrl_d  = ALU_SLL;
            src2_d  = mcand_d;
            shamt_d = SHAMT_W'(1);
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         ctrl_q    <= ALU_NOP;
         src1_q    <= '0;
         src2_q    <= '0;
         shamt_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         ctrl_q    <= ctrl_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         shamt_q   <= shamt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.product   = product_q;
   assign bus.alu_ctrl  = ctrl_q;
   assign bus.alu_src1  = src1_q;
   assign bus.alu_src2  = src2_q;
   assign bus.alu_shamt = shamt_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: driver pushes expected product and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_seq;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] prod;
      int unsigned  cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   mul_seq_if #(.bit_size(W)) bus ();

   mul_seq #(.bit_size(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Shared ALU sitting beside the multiplier at CPU level.
   always_comb begin
      case (bus.alu_ctrl)
         4'b0010: bus.alu_result = bus.alu_src1 + bus.alu_src2;
         4'b1000: bus.alu_result = bus.alu_src2 << bus.alu_shamt;
         default: bus.alu_result = '0;
      endcase
   end

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   int unsigned  cyc    = 0;
   int unsigned  dones  = 0;
   bit           mon_en = 1'b0;
   logic [W-1:0] held_exp = '0;
   exp_t         sb_q[$];
   exp_t         mon_e;
   logic [3:0]   ctrl_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return W'(p);
   endfunction

   // One ADD/SHL pair per bit up to the highest set bit, plus accept and DONE.
   function automatic int unsigned ref_lat(input logic [W-1:0] b);
      int unsigned k = 0;
      if (b == '0) return 1;
      for (int i = 0; i < int'(W); i++) if (b[i]) k = i;
      return 2 * k + 3;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.done) begin
            dones++;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 64'(bus.product), 64'hdead_0000_0000);
            end else begin
               mon_e = sb_q.pop_front();
               chk("product", 64'(bus.product), 64'(mon_e.prod));
               chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
               held_exp = mon_e.prod;
            end
         end else begin
            chk("product_hold", 64'(bus.product), 64'(held_exp));
         end
         if (!bus.busy || bus.done)
            chk("alu_idle", 64'(bus.alu_ctrl) | 64'(bus.alu_shamt) | 64'(bus.alu_src1 | bus.alu_src2), 64'd0);
         if (bus.busy && !bus.done) ctrl_log.push_back(bus.alu_ctrl);
      end
   end

   // Returns at a negedge where the block is idle; bounded.
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy) begin
         n++;
         if (n > 200) begin
            chk("idle_timeout", 64'd1, 64'd0);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        output int unsigned t0);
      wait_idle();
      ctrl_log.delete();
      bus.start     = 1'b1;
      bus.mcand_in  = a;
      bus.mplier_in = b;
      @(posedge clk);
      #1;
      t0 = cyc;
      sb_q.push_back('{prod: ref_mul(a, b), cyc: t0 + ref_lat(b) - 1});
      if (!hold) bus.start = 1'b0;
   endtask

   initial begin
      int unsigned  t0, t1, d0;
      logic [W-1:0] a, b;
      logic [3:0]   exp_ctrl;

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.mcand_in  = '0;
      bus.mplier_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_product", 64'(bus.product), 64'd0);
      chk("reset_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
      rst      = 1'b0;
      held_exp = '0;
      mon_en   = 1'b1;

      // 6 x 7: three ADD/SHL iterations
      issue(W'(6), W'(7), 1'b0, t0);
      wait_idle();
      chk("mul6x7_alu_cycles", 64'(ctrl_log.size()), 64'd6);
      for (int i = 0; i < ctrl_log.size(); i++) begin
         exp_ctrl = (i % 2 == 0) ? 4'b0010 : 4'b1000;
         chk("mul6x7_alu_ctrl", 64'(ctrl_log[i]), 64'(exp_ctrl));
      end
      chk("mul6x7_product_const", 64'(bus.product), 64'd42);

      // zero multiplier never enters ADD/SHL
      issue(W'(32'h1234), W'(0), 1'b0, t0);
      wait_idle();
      chk("zero_no_alu", 64'(ctrl_log.size()), 64'd0);

      // wrap-around
      issue(W'(32'hFFFF_FFFF), W'(32'hFFFF_FFFF), 1'b0, t0);
      wait_idle();
      chk("wrap_product_const", 64'(bus.product), 64'd1);

      // start pulse while busy is dropped
      d0 = dones;
      issue(W'(3), W'(5), 1'b0, t0);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.mcand_in  = W'(9);
      bus.mplier_in = W'(9);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("busy_ignore_dones", 64'(dones - d0), 64'd1);
      chk("busy_ignore_product", 64'(bus.product), 64'd15);

      // back-to-back with start held through DONE
      issue(W'(11), W'(13), 1'b1, t0);
      issue(W'(17), W'(19), 1'b0, t1);
      chk("b2b_accept_cycle", 64'(t1), 64'(t0 + ref_lat(W'(13)) - 1 + 2));
      wait_idle();

      // randomized operations, some back-to-back
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) b = '0;
         issue(a, b, (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0, t0);
      end
      wait_idle();

      // reset mid-run aborts; start during reset is ignored
      d0 = dones;
      issue(W'(32'h8000_0000), W'(32'h8000_0000), 1'b0, t0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb_q.delete();
      held_exp      = '0;
      bus.start     = 1'b1;
      bus.mcand_in  = W'(7);
      bus.mplier_in = W'(7);
      @(negedge clk);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_product", 64'(bus.product), 64'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_in_reset_busy", 64'(bus.busy), 64'd0);
      repeat (80) @(negedge clk);
      chk("midrst_no_done", 64'(dones - d0), 64'd0);

      // life after reset
      issue(W'(1234), W'(5678), 1'b0, t0);
      issue(W'(32'hDEAD_BEEF), W'(1), 1'b0, t0);
      wait_idle();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
